// File: rtl/pulse_train_generator.sv
// rtl/pulse_train_generator.sv - programmable pulse train source with count, high width and gap
// Optional endless repetition is built when PULSE_TRAIN_CONTINUOUS_EN is defined.
module pulse_train_generator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [CNT_W-1:0] gap_width,
    input  logic             abort,
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    input  logic             continuous,
`endif
    output logic             pulse,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_FIN
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] left_q;
    logic [CNT_W-1:0] w_m1_q;
    logic [CNT_W-1:0] g_m1_q;
    logic [CNT_W-1:0] w_m1_d;
    logic [CNT_W-1:0] g_m1_d;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    logic [CNT_W-1:0] n_q;
    logic             cont_q;
`endif

    // Phase counters hold "cycles left minus one", so a zero field maps to a single cycle.
    always_comb begin
        w_m1_d = (pulse_width == '0) ? '0 : pulse_width - CNT_W'(1);
        g_m1_d = (gap_width == '0) ? '0 : gap_width - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            left_q  <= '0;
            w_m1_q  <= '0;
            g_m1_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
            n_q     <= '0;
            cont_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        w_m1_q <= w_m1_d;
                        g_m1_q <= g_m1_d;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
                        n_q    <= num_pulses;
                        cont_q <= continuous;
`endif
                        if (num_pulses == '0) begin
                            state_q <= S_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_HIGH;
                            pulse_q <= 1'b1;
                            busy_q  <= 1'b1;
                            cnt_q   <= w_m1_d;
                            left_q  <= num_pulses - CNT_W'(1);
                        end
                    end
                end
                S_HIGH: begin
                    // left_q counts pulses still owed after the one currently high.
                    if (abort) begin
                        state_q <= S_FIN;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (left_q != '0) begin
                        state_q <= S_LOW;
                        pulse_q <= 1'b0;
                        cnt_q   <= g_m1_q;
                        left_q  <= left_q - CNT_W'(1);
`ifdef PULSE_TRAIN_CONTINUOUS_EN
                    end else if (cont_q) begin
                        state_q <= S_LOW;
                        pulse_q <= 1'b0;
                        cnt_q   <= g_m1_q;
                        left_q  <= n_q - CNT_W'(1);
`endif
                    end else begin
                        state_q <= S_FIN;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_LOW: begin
                    if (abort) begin
                        state_q <= S_FIN;
                        pulse_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= S_HIGH;
                        pulse_q <= 1'b1;
                        cnt_q   <= w_m1_q;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pulse_train_generator.sv
// tb/tb_pulse_train_generator.sv - randomized bench for pulse_train_generator against a waveform model
module tb_pulse_train_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] num_pulses;
    logic [7:0] pulse_width;
    logic [7:0] gap_width;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    logic       continuous;
`endif
    logic       pulse;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_train_generator #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_pulses  (num_pulses),
        .pulse_width (pulse_width),
        .gap_width   (gap_width),
        .abort       (abort),
`ifdef PULSE_TRAIN_CONTINUOUS_EN
        .continuous  (continuous),
`endif
        .pulse       (pulse),
        .busy        (busy),
        .done        (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int train_len(input int n, input int w, input int g);
        return (n == 0) ? 0 : n * eff(w) + (n - 1) * eff(g);
    endfunction

    // Expected waveform is built as a list of levels: W highs per pulse, G lows between pulses
    // (and after every pulse when repeating). Cycle k is the k-th cycle after the accepting edge.
    task automatic run_train(input string tag, input int n, input int w, input int g,
                             input int abort_at, input int rst_at, input bit cont,
                             input bit noise, input bit abort_with_start);
        int pat[$];
        int last;
        int exp_p;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < eff(w); i++) pat.push_back(1);
            if (p < n - 1 || cont)
                for (int i = 0; i < eff(g); i++) pat.push_back(0);
        end
        if (n == 0) last = 0;
        else if (cont) last = abort_at;
        else if (abort_at > 0 && abort_at <= pat.size()) last = abort_at;
        else last = pat.size();

        @(negedge clk);
        start       = 1'b1;
        abort       = abort_with_start;
        num_pulses  = 8'(n);
        pulse_width = 8'(w);
        gap_width   = 8'(g);
`ifdef PULSE_TRAIN_CONTINUOUS_EN
        continuous  = cont;
`endif
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clk);
            if (rst_at > 0 && k == rst_at + 1) begin
                check_eq($sformatf("%s rst pulse c%0d", tag, k), {31'b0, pulse}, 0);
                check_eq($sformatf("%s rst busy c%0d", tag, k), {31'b0, busy}, 0);
                check_eq($sformatf("%s rst done c%0d", tag, k), {31'b0, done}, 0);
                rst   = 1'b0;
                start = 1'b0;
                abort = 1'b0;
                return;
            end
            exp_p = 0;
            if (k <= last) exp_p = pat[(k - 1) % pat.size()];
            check_eq($sformatf("%s pulse c%0d", tag, k), {31'b0, pulse}, exp_p);
            check_eq($sformatf("%s busy c%0d", tag, k), {31'b0, busy}, (k <= last) ? 1 : 0);
            check_eq($sformatf("%s done c%0d", tag, k), {31'b0, done}, (k == last + 1) ? 1 : 0);
            start = 1'b0;
            abort = 1'b0;
            if (noise && k <= last + 1) begin
                start       = 1'($urandom);
                num_pulses  = 8'($urandom);
                pulse_width = 8'($urandom);
                gap_width   = 8'($urandom);
            end
            if (k == abort_at && k <= last) abort = 1'b1;
            if (k == rst_at) rst = 1'b1;
        end
    endtask

    initial begin
        int n, w, g, len, ab, rs;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        num_pulses  = '0;
        pulse_width = '0;
        gap_width   = '0;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
        continuous  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_eq("reset pulse", {31'b0, pulse}, 0);
        check_eq("reset busy", {31'b0, busy}, 0);
        check_eq("reset done", {31'b0, done}, 0);
        rst = 1'b0;

        run_train("basic", 3, 1, 1, 0, 0, 1'b0, 1'b0, 1'b0);
        run_train("zero_wg", 2, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_train("wide", 1, 4, 7, 0, 0, 1'b0, 1'b0, 1'b0);
        run_train("zero_n", 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        run_train("abort_low", 5, 2, 3, 9, 0, 1'b0, 1'b1, 1'b0);
        run_train("rst_high", 3, 3, 2, 0, 2, 1'b0, 1'b0, 1'b0);
        run_train("after_rst", 1, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_train("start_abort", 2, 1, 1, 0, 0, 1'b0, 1'b0, 1'b1);
        run_train("max_n", 255, 1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_train("max_wg", 2, 255, 255, 0, 0, 1'b0, 1'b1, 1'b0);
        run_train("abort_high", 3, 4, 2, 2, 0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            n   = $urandom_range(0, 6);
            w   = $urandom_range(0, 4);
            g   = $urandom_range(0, 4);
            len = train_len(n, w, g);
            ab  = 0;
            rs  = 0;
            if (len > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, len);
            else if (len > 0 && $urandom_range(0, 5) == 0) rs = $urandom_range(1, len);
            run_train($sformatf("rnd%0d", t), n, w, g, ab, rs, 1'b0, 1'($urandom), 1'($urandom));
        end

`ifdef PULSE_TRAIN_CONTINUOUS_EN
        run_train("cont", 2, 1, 2, 20, 0, 1'b1, 1'b0, 1'b0);
        run_train("cont_zero", 0, 1, 2, 0, 0, 1'b1, 1'b0, 1'b0);
        run_train("cont_wide", 3, 2, 0, 31, 0, 1'b1, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_train_generator.md
Name: pulse_train_generator

Overview:
- Transmit-side counterpart to the team's edge and pulse detectors.
- On a start request, drives a programmable train of pulses on a single output: count, high width and low gap are all programmable.
- Used as the stimulus source for pulse-detecting logic and as a general strobe generator.
- Single clock domain, registered output.

Parameters:
- CNT_W, 8, width of the count, width and gap fields and of the internal counters.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to begin a train; sampled only in IDLE.
- num_pulses  input  CNT_W  number of pulses in the train; latched on accepted start.
- pulse_width  input  CNT_W  high cycles per pulse; latched on accepted start; 0 treated as 1.
- gap_width  input  CNT_W  low cycles between pulses; latched on accepted start; 0 treated as 1.
- abort  input  1  terminate the current train.
- pulse  output  1  generated pulse train, registered.
- busy  output  1  high from the cycle after an accepted start until the train ends.
- done  output  1  one-cycle strobe when a train completes or is aborted.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE.
  - pulse=0, busy=0, done=0.
  - All counters and latched fields are cleared.
  - Reset has priority over every other input, including mid-train. pulse drops to 0 on the next cycle; no done strobe.
- States: IDLE, HIGH, LOW, FIN.
- IDLE:
  - pulse=0, busy=0.
  - Start is accepted when start=1 in IDLE; num_pulses, pulse_width and gap_width are latched on that edge.
  - If num_pulses==0: go to FIN (no pulses emitted).
  - Otherwise: go to HIGH.
  - start while not in IDLE is ignored.
- HIGH:
  - pulse=1, busy=1.
  - Stays for exactly max(pulse_width,1) cycles.
  - Then, if pulses remaining after this one > 0: go to LOW.
  - Else: go to FIN.
- LOW:
  - pulse=0, busy=1.
  - Stays for exactly max(gap_width,1) cycles, then goes to HIGH.
- FIN:
  - pulse=0, busy=0, done=1 for exactly one cycle.
  - Then IDLE.
  - A start present during FIN is ignored; start must be presented in IDLE.
- Latency:
  - Start accepted at edge t: pulse first high in cycle t+1.
  - The last high cycle ends at edge e; done=1 in cycle e+1.
  - No trailing gap after the last pulse.
- Total busy cycles = N*W + (N-1)*G, with W and G after zero-substitution.
- abort:
  - In HIGH or LOW, abort=1 goes to FIN on the next edge: pulse=0 immediately after, done strobes once.
  - In IDLE or FIN, abort is ignored.
  - abort and start together in IDLE: abort is ignored and start is accepted.
- Counters:
  - Down-counters of CNT_W bits; no wrap-around is possible.
  - num_pulses = 2^CNT_W-1 is supported, as are maximum width and gap.
- Input fields change while busy: no effect.

Optional Feature:
- Macro: PULSE_TRAIN_CONTINUOUS_EN.
- When defined:
  - Adds input port continuous (1 bit), sampled with start.
  - If latched continuous=1, after the last pulse the FSM enters LOW (gap) and reloads the pulse count instead of entering FIN. This repeats indefinitely.
  - The train ends only via abort (done strobes) or rst.
  - If continuous=1 and num_pulses==0, go to FIN as normal.
- When not defined:
  - Port is absent.
  - Behaviour is exactly as described above.

Test Plan:
- Basic train: rst 2 cycles, then start with N=3, W=1, G=1.
  - pulse = 1,0,1,0,1 in cycles t+1..t+5.
  - busy high for those 5 cycles.
  - done=1 in cycle t+6 only.
- Zero substitution: N=2, W=0, G=0 -> pulse 1,0,1; done one cycle after the last high.
- Wide and zero-count trains:
  - N=1, W=4, G=7 -> pulse high 4 cycles, no gap, done on the 5th cycle.
  - N=0 -> no pulse, busy stays 0, done one cycle after start.
- Abort and ignored start:
  - N=5, W=2, G=3; assert abort in the second LOW cycle -> pulse stays 0, done once, IDLE next.
  - A start asserted mid-train is ignored; total high cycles = 4 before the abort.
- Reset mid-HIGH:
  - rst during a pulse -> pulse=0, busy=0, done=0 next cycle.
  - A subsequent start with N=1, W=1 works normally.
- Continuous mode (PULSE_TRAIN_CONTINUOUS_EN): continuous=1, N=2, W=1, G=2.
  - Repeating period 1,0,0,1,0,0 with no done.
  - abort -> done strobe, then IDLE.
